// File: rtl/button_bank_pkg.sv
// Shared types and helpers for the button bank decoder.
package button_bank_pkg;

  // Widest button bank the lowest_index helper can scan.
  localparam int MAX_BTN = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_e;

  // Bits needed to hold a 1-based button index plus the "none" code 0.
  function automatic int code_width(input int n);
    return $clog2(n + 1);
  endfunction

  // 1-based index of the lowest set bit, 0 when no bit is set.
  function automatic int lowest_index(input logic [MAX_BTN-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_BTN - 1; i >= 0; i--) begin
      if (vec[i]) idx = i + 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: metastability synchroniser followed by a
// stability counter. The debounced level only follows the synchronised
// level after it has differed for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_raw,
  output logic deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   sync_bit;

  // Bit 0 takes the raw pin, the top bit is the synchronised level.
  assign sync_bit = sync_q[SYNC_STAGES-1];
  assign deb      = deb_q;

  // Next-state: shift the synchroniser and run the stability counter.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (sync_bit == deb_q) begin
      // Level agrees with the accepted one: any pending change was a bounce.
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync_bit;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

endmodule

// File: rtl/button_bank_decoder.sv
// Button bank decoder: NUM_BTN debounced channels feed an IDLE/HELD FSM
// that emits one btn_valid pulse per press with a 1-based button code.
// Optional auto-repeat while held: define BUTTON_BANK_AUTO_REPEAT_EN.
// Output handshake: btn_valid is a single-cycle strobe with no ready;
// btn_code/btn_multi are valid in that cycle and hold until the next event.
module button_bank_decoder
  import button_bank_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250,
  parameter int CODE_W          = code_width(NUM_BTN)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic              btn_valid,
  output logic [CODE_W-1:0] btn_code,
  output logic              btn_multi,
  output logic              btn_held
);

  // Reject unusable configurations at elaboration time.
  if (NUM_BTN < 1 || NUM_BTN > MAX_BTN || SYNC_STAGES < 2 ||
      DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_bank_decoder: illegal parameter combination");
  end

  logic [NUM_BTN-1:0] deb;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .nrst    (nrst),
      .btn_raw (btn_in[i]),
      .deb     (deb[i])
    );
  end

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              multi_q, multi_d;
  logic              multi_hot;

`ifdef BUTTON_BANK_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  // 0 while waiting for the first repeat, 1 once in the periodic phase.
  logic             phase_q, phase_d;
  logic [RPT_W-1:0] rpt_target;

  assign rpt_target = phase_q ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);
`endif

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_hot = |(deb & (deb - NUM_BTN'(1)));

  assign btn_valid = valid_q;
  assign btn_code  = code_q;
  assign btn_multi = multi_q;
  assign btn_held  = (state_q == HELD);

  // FSM next-state and event encoding.
  always_comb begin
    state_d = state_q;
    valid_d = 1'b0;
    code_d  = code_q;
    multi_d = multi_q;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (|deb) begin
          valid_d = 1'b1;
          code_d  = CODE_W'(lowest_index(MAX_BTN'(deb)));
          multi_d = multi_hot;
          state_d = HELD;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
          rpt_d   = '0;
          phase_d = 1'b0;
`endif
        end
      end
      HELD: begin
        if (deb == '0) begin
          state_d = IDLE;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
          rpt_d   = '0;
          phase_d = 1'b0;
`endif
        end else begin
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
          // Repeat events re-pulse btn_valid but keep code/multi.
          if (rpt_q == rpt_target) begin
            valid_d = 1'b1;
            rpt_d   = '0;
            phase_d = 1'b1;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered output flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      multi_q <= 1'b0;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      rpt_q   <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      multi_q <= multi_d;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      rpt_q   <= rpt_d;
      phase_q <= phase_d;
`endif
    end
  end

endmodule

// File: tb/tb_button_bank_decoder.sv
// Directed bench for button_bank_decoder (NUM_BTN=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, so "after edge k" means sampled at k + 1 unit.
module tb_button_bank_decoder;

  localparam int NB  = 4;
  localparam int SS  = 2;
  localparam int DC  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = SS + DC + 1;  // press applied after edge k -> valid after edge k+LAT

  logic          clk;
  logic          nrst;
  logic [NB-1:0] btn_in;
  logic          btn_valid;
  logic [2:0]    btn_code;
  logic          btn_multi;
  logic          btn_held;

  int n_vec;
  int n_err;

  button_bank_decoder #(
    .NUM_BTN         (NB),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .btn_in    (btn_in),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .btn_multi (btn_multi),
    .btn_held  (btn_held)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release all buttons and wait out a release debounce.
  task automatic settle();
    btn_in = '0;
    for (int i = 0; i < LAT + 3; i++) tick();
  endtask

  task automatic test_reset();
    nrst   = 1'b0;
    btn_in = '0;
    #2;
    n_vec++;
    if (btn_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", btn_valid); end
    n_vec++;
    if (btn_code !== 3'd0) begin n_err++; $display("FAIL reset_code got %0d want 0", btn_code); end
    n_vec++;
    if (btn_multi !== 1'b0) begin n_err++; $display("FAIL reset_multi got %b want 0", btn_multi); end
    n_vec++;
    if (btn_held !== 1'b0) begin n_err++; $display("FAIL reset_held got %b want 0", btn_held); end
    tick();
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (btn_valid !== 1'b0 || btn_held !== 1'b0 || btn_code !== 3'd0) begin
        n_err++;
        $display("FAIL idle_after_reset i=%0d got v=%b h=%b c=%0d want 0 0 0", i, btn_valid, btn_held, btn_code);
      end
    end
  endtask

  task automatic test_single_press();
    logic exp_v;
    btn_in = 4'b0100;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      exp_v = (i == LAT);
      n_vec++;
      if (btn_valid !== exp_v) begin n_err++; $display("FAIL press_valid i=%0d got %b want %b", i, btn_valid, exp_v); end
      n_vec++;
      if (btn_held !== (i >= LAT)) begin n_err++; $display("FAIL press_held i=%0d got %b want %b", i, btn_held, (i >= LAT)); end
      if (i == LAT) begin
        n_vec++;
        if (btn_code !== 3'd3) begin n_err++; $display("FAIL press_code got %0d want 3", btn_code); end
        n_vec++;
        if (btn_multi !== 1'b0) begin n_err++; $display("FAIL press_multi got %b want 0", btn_multi); end
      end
    end
    btn_in = '0;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      n_vec++;
      if (btn_held !== (i < LAT)) begin n_err++; $display("FAIL release_held i=%0d got %b want %b", i, btn_held, (i < LAT)); end
      n_vec++;
      if (btn_valid !== 1'b0) begin n_err++; $display("FAIL release_valid i=%0d got %b want 0", i, btn_valid); end
    end
  endtask

  task automatic test_bounce();
    logic exp_v;
    btn_in = 4'b0001;
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_v = (i == 4 + LAT);  // latency from the last rising edge, applied after edge 4
      n_vec++;
      if (btn_valid !== exp_v) begin n_err++; $display("FAIL bounce_valid i=%0d got %b want %b", i, btn_valid, exp_v); end
      if (exp_v) begin
        n_vec++;
        if (btn_code !== 3'd1) begin n_err++; $display("FAIL bounce_code got %0d want 1", btn_code); end
      end
      if (i == 2) btn_in = 4'b0000;
      if (i == 4) btn_in = 4'b0001;
    end
    settle();
  endtask

  task automatic test_glitch();
    btn_in = 4'b0010;
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_vec++;
      if (btn_valid !== 1'b0 || btn_held !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_event i=%0d got v=%b h=%b want 0 0", i, btn_valid, btn_held);
      end
      n_vec++;
      if (btn_code !== 3'd1) begin n_err++; $display("FAIL glitch_code i=%0d got %0d want 1", i, btn_code); end
      if (i == 3) btn_in = 4'b0000;
    end
  endtask

  task automatic test_multi_press();
    logic exp_v;
    btn_in = 4'b1010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_v = (i == LAT);
      n_vec++;
      if (btn_valid !== exp_v) begin n_err++; $display("FAIL multi_valid i=%0d got %b want %b", i, btn_valid, exp_v); end
      if (exp_v) begin
        n_vec++;
        if (btn_code !== 3'd2) begin n_err++; $display("FAIL multi_code got %0d want 2", btn_code); end
        n_vec++;
        if (btn_multi !== 1'b1) begin n_err++; $display("FAIL multi_flag got %b want 1", btn_multi); end
      end
    end
    btn_in = 4'b1011;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_vec++;
      if (btn_valid !== 1'b0 || btn_held !== 1'b1) begin
        n_err++;
        $display("FAIL held_ignore i=%0d got v=%b h=%b want 0 1", i, btn_valid, btn_held);
      end
    end
    btn_in = '0;
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      n_vec++;
      if (btn_held !== (i < LAT)) begin n_err++; $display("FAIL multi_release i=%0d got %b want %b", i, btn_held, (i < LAT)); end
      n_vec++;
      if (btn_valid !== 1'b0) begin n_err++; $display("FAIL multi_release_valid i=%0d got %b want 0", i, btn_valid); end
    end
    n_vec++;
    if (btn_code !== 3'd2 || btn_multi !== 1'b1) begin
      n_err++;
      $display("FAIL multi_hold_regs got c=%0d m=%b want 2 1", btn_code, btn_multi);
    end
  endtask

  task automatic test_reset_mid_press();
    logic exp_v;
    btn_in = 4'b0001;
    for (int i = 1; i <= 10; i++) tick();
    n_vec++;
    if (btn_held !== 1'b1 || btn_code !== 3'd1) begin
      n_err++;
      $display("FAIL pre_reset_held got h=%b c=%0d want 1 1", btn_held, btn_code);
    end
    nrst = 1'b0;
    #1;
    n_vec++;
    if (btn_valid !== 1'b0 || btn_code !== 3'd0 || btn_multi !== 1'b0 || btn_held !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got v=%b c=%0d m=%b h=%b want 0 0 0 0", btn_valid, btn_code, btn_multi, btn_held);
    end
    tick();
    tick();
    nrst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_v = (i == LAT);
      n_vec++;
      if (btn_valid !== exp_v) begin n_err++; $display("FAIL post_reset_valid i=%0d got %b want %b", i, btn_valid, exp_v); end
      n_vec++;
      if (btn_code !== ((i >= LAT) ? 3'd1 : 3'd0)) begin
        n_err++;
        $display("FAIL post_reset_code i=%0d got %0d want %0d", i, btn_code, (i >= LAT) ? 1 : 0);
      end
    end
    settle();
  endtask

  task automatic test_hold_repeat();
    logic exp_v;
    logic exp_h;
    int   d;
    btn_in = 4'b1000;
    for (int i = 1; i <= LAT + 60; i++) begin
      tick();
      d = i - LAT;
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
      exp_v = (d == 0) || (d == RD) || (d == RD + RP) || (d == RD + 2 * RP);
`else
      exp_v = (d == 0);
`endif
      exp_h = (d >= 0) && (d <= 32 + LAT - 1);
      n_vec++;
      if (btn_valid !== exp_v) begin n_err++; $display("FAIL hold_valid d=%0d got %b want %b", d, btn_valid, exp_v); end
      n_vec++;
      if (btn_held !== exp_h) begin n_err++; $display("FAIL hold_held d=%0d got %b want %b", d, btn_held, exp_h); end
      if (exp_v) begin
        n_vec++;
        if (btn_code !== 3'd4 || btn_multi !== 1'b0) begin
          n_err++;
          $display("FAIL hold_code d=%0d got c=%0d m=%b want 4 0", d, btn_code, btn_multi);
        end
      end
      if (d == 32) btn_in = 4'b0000;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    nrst   = 1'b0;
    btn_in = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_glitch();
    test_multi_press();
    test_reset_mid_press();
    test_hold_repeat();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_bank_decoder.md
Name: button_bank_decoder

Overview:
- Parametrised successor to the 4-button register-select decoder.
- Synchronises and debounces NUM_BTN raw push-buttons, then emits one press event per press.
- Encodes the pressed button as a 1-based index; multiple simultaneous presses are flagged.
- Sits between the board button pins and the command/register-select logic.

Parameters:
- NUM_BTN, 4: number of button channels (>=1).
- SYNC_STAGES, 2: flip-flop stages per channel synchroniser (>=2).
- DEBOUNCE_CYCLES, 16: consecutive stable cycles needed to accept a level change (>=1).
- REPEAT_DELAY, 1000: cycles from the initial event to the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 250: cycles between subsequent auto-repeats (used only with AUTO_REPEAT_EN).
- CODE_W, $clog2(NUM_BTN+1): derived width of btn_code; not to be overridden.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- btn_in  in  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- btn_valid  out  1  one-cycle event pulse.
- btn_code  out  CODE_W  1-based index of the accepted button; 0 = none since reset.
- btn_multi  out  1  more than one button was active at the accepted event.
- btn_held  out  1  high while the decoder is in HELD.

Behaviour:
- Reset (async, nrst=0): all synchroniser flops, debounce counters and debounced levels go to 0; FSM goes to IDLE; btn_valid=0, btn_code=0, btn_multi=0, btn_held=0. Reset mid-press discards everything. A press still held after reset release must pass the full sync + debounce path again before it produces an event.
- Synchroniser, per channel: SYNC_STAGES-deep shift register; sync[i] is the last stage.
- Debounce, per channel:
  - Counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync[i]==deb[i]: cnt<=0.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1: deb[i]<=sync[i] and cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes deb. Counting restarts on every bounce.
- FSM states IDLE and HELD:
  - IDLE: if |deb, then next cycle btn_valid=1, btn_code = lowest set index of deb + 1, btn_multi = (popcount(deb) > 1), and the FSM goes to HELD. Otherwise stay in IDLE.
  - HELD: btn_held=1. Presses of other buttons are ignored. When deb==0 (all released), go to IDLE. Only IDLE can emit a fresh event, so each event requires a full release first.
- btn_valid is high for exactly one cycle per event.
- btn_code and btn_multi are registered, update only on an event, and hold their value until the next event.
- Latency: a clean press stable from clock edge k produces btn_valid high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Simultaneous edges on several channels in the same cycle: one event only, lowest index wins, btn_multi=1.
- Release and a new press in the same cycle are impossible by construction, because HELD exits only when deb==0.
- Counters saturate or wrap only as specified here; no other state exists.

Optional Feature:
- Macro name: BUTTON_BANK_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter runs in HELD. It starts at 0 on HELD entry and, by target, re-emits a btn_valid pulse REPEAT_DELAY cycles after the initial event, then every REPEAT_PERIOD cycles.
  - Repeat events leave btn_code and btn_multi unchanged.
  - The counter clears on exit from HELD and on reset.
  - Counter width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- Undefined: no repeat counter is instantiated; one btn_valid per press; REPEAT_* parameters are ignored.

Decomposition:
- Package button_bank_pkg:
  - state enum (IDLE, HELD).
  - function code_width(n) returning $clog2(n+1).
  - function lowest_index(vec) returning a 1-based index, 0 if empty.
- Sub-module btn_debounce: one channel's synchroniser plus debounce counter, parameters SYNC_STAGES and DEBOUNCE_CYCLES, output deb. Instantiated NUM_BTN times via generate.
- FSM and encoding stay in the top module.

Test Plan:
- Test 1 (NUM_BTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4): btn_in=4'b0100 held from edge 10 -> single btn_valid after edge 17, btn_code=3, btn_multi=0, btn_held=1 until release is debounced.
- Test 2, bounce: btn_in[0] toggles 1,0,1 with 2-cycle spacing, then stays 1 -> exactly one event, btn_code=1, latency counted from the last rising edge.
- Test 3, glitch: 3-cycle pulse on btn_in[1] with DEBOUNCE_CYCLES=4 -> no btn_valid; btn_code stays at its previous value.
- Test 4, simultaneous press: btn_in=4'b1010 in the same cycle -> one event, btn_code=2, btn_multi=1. Then press btn_in[0] while still held -> no event until all buttons are released.
- Test 5, reset mid-operation: nrst pulsed low while in HELD with btn_in=4'b0001 held -> outputs 0 immediately; after nrst rises, a new event fires after SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
- Test 6, with BUTTON_BANK_AUTO_REPEAT_EN (REPEAT_DELAY=20, REPEAT_PERIOD=8): hold btn_in[3] -> events at t0, t0+20, t0+28, t0+36, all with btn_code=4; repeats stop once the release is debounced.
